experimental: RTL and testbench

EXPERIMENTAL -- requirements
Module: experimental

---
 rtl/experimental.sv | 110 +++++++++++
 tb/tb_experimental.sv | 104 ++++++++++
 2 files changed

// File: rtl/experimental.sv
// Autonomous 4-bit pattern generator: binary, Gray, LFSR and Johnson phases
// in a fixed 55-step loop, each value held for DIV clock cycles.
//
// state | meaning
// BIN   | x = n, 16 steps
// GRAY  | x = n ^ (n >> 1), 16 steps
// LFSR  | x shifts with feedback x[3]^x[2], 15 steps from 4'h1
// JOHN  | x shifts with feedback ~x[3], 8 steps from 4'h0
module experimental #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] x
);

    typedef enum logic [1:0] {
        BIN  = 2'd0,
        GRAY = 2'd1,
        LFSR = 2'd2,
        JOHN = 2'd3
    } phase_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    phase_t     phase_q, phase_d;
    logic [7:0] pre_q, pre_d;
    logic [3:0] n_q, n_d;
    logic [3:0] x_q, x_d;
    logic [3:0] n_inc;
    logic       step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= BIN;
            pre_q   <= 8'd0;
            n_q     <= 4'd0;
            x_q     <= 4'h0;
        end else begin
            phase_q <= phase_d;
            pre_q   <= pre_d;
            n_q     <= n_d;
            x_q     <= x_d;
        end
    end

    // Each branch loads the first value of the next phase directly on its
    // last step, so phase boundaries cost no extra step.
    always_comb begin
        step    = (pre_q == DIV_LAST);
        pre_d   = step ? 8'd0 : pre_q + 8'd1;
        phase_d = phase_q;
        n_d     = n_q;
        x_d     = x_q;
        n_inc   = n_q + 4'd1;
        if (step) begin
            case (phase_q)
                BIN: begin
                    if (n_q == 4'd15) begin
                        phase_d = GRAY;
                        n_d     = 4'd0;
                        x_d     = 4'h0;
                    end else begin
                        n_d = n_inc;
                        x_d = n_inc;
                    end
                end
                GRAY: begin
                    if (n_q == 4'd15) begin
                        phase_d = LFSR;
                        n_d     = 4'd0;
                        x_d     = 4'h1;
                    end else begin
                        n_d = n_inc;
                        x_d = n_inc ^ (n_inc >> 1);
                    end
                end
                LFSR: begin
                    if (n_q == 4'd14) begin
                        phase_d = JOHN;
                        n_d     = 4'd0;
                        x_d     = 4'h0;
                    end else begin
                        n_d = n_inc;
                        // All-zero is the LFSR lock-up state; kick it back to 1.
                        x_d = (x_q == 4'h0) ? 4'h1 : {x_q[2:0], x_q[3] ^ x_q[2]};
                    end
                end
                JOHN: begin
                    if (n_q == 4'd7) begin
                        phase_d = BIN;
                        n_d     = 4'd0;
                        x_d     = 4'h0;
                    end else begin
                        n_d = n_inc;
                        x_d = {x_q[2:0], ~x_q[3]};
                    end
                end
                default: begin
                    phase_d = BIN;
                    n_d     = 4'd0;
                    x_d     = 4'h0;
                end
            endcase
        end
    end

    assign x = x_q;

endmodule

// File: tb/tb_experimental.sv
// Directed bench for experimental: reset, full 55-step loop at DIV=1,
// phase boundaries, async reset in the LFSR phase, and prescaling at DIV=3.
module tb_experimental;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1;
    logic       rst3 = 1'b1;
    logic [3:0] x1;
    logic [3:0] x3;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_seq [0:54] = '{
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF,
        4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8,
        4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
        4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8,
        4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8
    };

    logic [3:0] cap [0:110];

    // boundary pairs: index of last value of a phase, its value, next value
    int         bnd_idx  [0:3] = '{15, 31, 46, 54};
    logic [3:0] bnd_last [0:3] = '{4'hF, 4'h8, 4'h8, 4'h8};
    logic [3:0] bnd_next [0:3] = '{4'h0, 4'h1, 4'h0, 4'h0};

    experimental #(.DIV(1)) dut1 (.clk(clk), .rst(rst1), .x(x1));
    experimental #(.DIV(3)) dut3 (.clk(clk), .rst(rst3), .x(x3));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    initial begin
        int f0_first;
        int f0_second;
        logic [3:0] prev;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_x1", 32'(x1), 32'h0);
            check("reset_x3", 32'(x3), 32'h0);
        end

        @(posedge clk);
        #1 rst1 = 1'b0;
        #1 check("post_release_hold", 32'(x1), 32'h0);
        cap[0] = x1;

        for (int i = 1; i <= 110; i++) begin
            @(posedge clk);
            #1;
            cap[i] = x1;
            check($sformatf("seq_%0d", i), 32'(cap[i]), 32'(exp_seq[i % 55]));
        end

        for (int b = 0; b < 4; b++) begin
            check($sformatf("bnd_last_%0d", bnd_idx[b]), 32'(cap[bnd_idx[b]]), 32'(bnd_last[b]));
            check($sformatf("bnd_next_%0d", bnd_idx[b] + 1), 32'(cap[bnd_idx[b] + 1]), 32'(bnd_next[b]));
        end

        // advance to step 145, which sits inside the LFSR phase (x = 9)
        repeat (35) @(posedge clk);
        #1 check("pre_reset_lfsr", 32'(x1), 32'h9);
        #1 rst1 = 1'b1;
        #1 check("async_reset_during", 32'(x1), 32'h0);
        #1 rst1 = 1'b0;
        #2 check("async_reset_after", 32'(x1), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1 check($sformatf("restart_%0d", k), 32'(x1), 32'(exp_seq[k]));
        end

        @(posedge clk);
        #1 rst3 = 1'b0;
        f0_first  = -1;
        f0_second = -1;
        prev      = x3;
        for (int c = 1; c <= 330; c++) begin
            @(posedge clk);
            #1 check($sformatf("div3_cyc_%0d", c), 32'(x3), 32'(exp_seq[(c / 3) % 55]));
            if (prev == 4'hF && x3 == 4'h0) begin
                if (f0_first < 0) f0_first = c;
                else if (f0_second < 0) f0_second = c;
            end
            prev = x3;
        end
        check("div3_period", 32'(f0_second - f0_first), 32'd165);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
